fusion_pipeline_sequencer: RTL and testbench

FUSION_PIPELINE_SEQUENCER -- requirements
Module: fusion_pipeline_sequencer

---
 rtl/fusion_seq_pkg.sv | 31 +++
 rtl/fusion_seq_timer.sv | 34 +++
 rtl/fusion_pipeline_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fusion_pipeline_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_seq_pkg.sv
// Shared definitions for the fusion pipeline sequencer.
//   state_t           : sequencer states, IDLE through OUTPUT
//   SENSOR_*          : bit index of each sensor in the 4-bit sensor_valid bus
//   SENSOR_ALL        : seen_mask value meaning every sensor has reported
//   ERR_*             : bit positions inside the 8-bit error_flags output
package fusion_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_ALIGN   = 3'd2,
      S_EXTRACT = 3'd3,
      S_FUSE    = 3'd4,
      S_OUTPUT  = 3'd5
   } state_t;

   localparam int SENSOR_CAMERA = 0;
   localparam int SENSOR_LIDAR  = 1;
   localparam int SENSOR_RADAR  = 2;
   localparam int SENSOR_IMU    = 3;

   localparam logic [3:0] SENSOR_ALL = 4'((1 << SENSOR_CAMERA) | (1 << SENSOR_LIDAR) |
                                          (1 << SENSOR_RADAR)  | (1 << SENSOR_IMU));

   localparam int ERR_WINDOW   = 0;
   localparam int ERR_OVERRUN  = 1;
   localparam int ERR_TIMEOUT  = 2;
   localparam int ERR_SPURIOUS = 3;
   localparam int ERR_MISS_LSB = 4;

endpackage

// File: rtl/fusion_seq_timer.sv
// Wait-cycle counter shared by the collection window and the stage waits.
//   clk, rst  : clock and synchronous active-high reset
//   clear     : zero the count (takes priority over enable)
//   enable    : advance the count by one this cycle
//   limit     : runtime terminal value
//   terminal  : high while the count equals limit
module fusion_seq_timer #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             terminal
);

   logic [WIDTH-1:0] count;

   assign terminal = (count == limit);

   // The owning FSM always leaves the waiting state on terminal, so the
   // counter never needs to saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fusion_pipeline_sequencer.sv
// Sequences one sensor-fusion frame: collect all four sensors inside a
// window, then start alignment, feature extraction and fusion in turn, and
// hold the fused frame until the consumer accepts it.
//   clk, rst              : clock, synchronous active-high reset
//   sensor_valid[3:0]     : camera, lidar, radar, imu valid pulses
//   align_start/done      : temporal alignment handshake
//   feat_start/done[2:0]  : feature extractor handshake (camera, lidar, radar)
//   fuse_start/done       : fusion core handshake
//   frame_valid/out_ready : output frame handshake
//   err_clear             : clears sticky error_flags
//   busy                  : high whenever the sequencer is not idle
//   error_flags[7:0]      : window miss, overrun, timeout, spurious done, missing mask
//   frame_count[15:0]     : accepted frames, wraps at 16'hFFFF
module fusion_pipeline_sequencer
   import fusion_seq_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1024,
   parameter int STAGE_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sensor_valid,
   output logic        align_start,
   input  logic        align_done,
   output logic        feat_start,
   input  logic [2:0]  feat_done,
   output logic        fuse_start,
   input  logic        fuse_done,
   output logic        frame_valid,
   input  logic        out_ready,
   input  logic        err_clear,
   output logic        busy,
   output logic [7:0]  error_flags,
   output logic [15:0] frame_count
);

   localparam int MAX_CYCLES = (WINDOW_CYCLES > STAGE_TIMEOUT) ? WINDOW_CYCLES : STAGE_TIMEOUT;
   localparam int TIMER_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

   state_t              state;
   state_t              next_state;
   logic [3:0]          seen_mask;
   logic [3:0]          next_seen;
   logic [2:0]          done_mask;
   logic [2:0]          next_done;
   logic [7:0]          next_err;
   logic [15:0]         next_count;
   logic [3:0]          collect_mask;
   logic [2:0]          extract_mask;
   logic                timer_clear;
   logic                timer_enable;
   logic                timer_hit;
   logic [TIMER_W-1:0]  timer_limit;

   assign collect_mask = seen_mask | sensor_valid;
   assign extract_mask = done_mask | feat_done;

   // The collection window and the stage waits never overlap, so one
   // counter serves both with a limit chosen by the current state.
   assign timer_limit = (state == S_COLLECT) ? TIMER_W'(WINDOW_CYCLES - 1)
                                             : TIMER_W'(STAGE_TIMEOUT - 1);

   fusion_seq_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .limit    (timer_limit),
      .terminal (timer_hit)
   );

   // Next-state, mask and error logic. Errors raised this cycle are OR'd in
   // after err_clear has been applied so that a fresh error survives a clear.
   // Done pulses are tested before the timer so a late done still wins.
   always_comb begin
      next_state   = state;
      next_seen    = seen_mask;
      next_done    = done_mask;
      next_count   = frame_count;
      next_err     = err_clear ? 8'h00 : error_flags;
      timer_enable = 1'b0;
      timer_clear  = 1'b0;

      if (align_done && (state != S_ALIGN)) next_err[ERR_SPURIOUS] = 1'b1;
      if ((feat_done != 3'b000) && (state != S_EXTRACT)) next_err[ERR_SPURIOUS] = 1'b1;
      if (fuse_done && (state != S_FUSE)) next_err[ERR_SPURIOUS] = 1'b1;
      if ((sensor_valid != 4'h0) && (state inside {S_ALIGN, S_EXTRACT, S_FUSE, S_OUTPUT}))
         next_err[ERR_OVERRUN] = 1'b1;

      case (state)
         S_IDLE: begin
            if (sensor_valid != 4'h0) begin
               next_seen  = sensor_valid;
               next_state = S_COLLECT;
            end
         end
         S_COLLECT: begin
            timer_enable = 1'b1;
            if (collect_mask == SENSOR_ALL) begin
               next_seen  = 4'h0;
               next_state = S_ALIGN;
            end else if (timer_hit) begin
               next_err[ERR_WINDOW]          = 1'b1;
               next_err[ERR_MISS_LSB +: 4]   = ~collect_mask;
               next_seen                     = 4'h0;
               next_state                    = S_IDLE;
            end else begin
               next_seen = collect_mask;
            end
         end
         S_ALIGN: begin
            timer_enable = 1'b1;
            if (align_done) begin
               next_done  = 3'b000;
               next_state = S_EXTRACT;
            end else if (timer_hit) begin
               next_err[ERR_TIMEOUT] = 1'b1;
               next_state            = S_IDLE;
            end
         end
         S_EXTRACT: begin
            timer_enable = 1'b1;
            if (extract_mask == 3'b111) begin
               next_done  = 3'b000;
               next_state = S_FUSE;
            end else if (timer_hit) begin
               next_err[ERR_TIMEOUT] = 1'b1;
               next_done             = 3'b000;
               next_state            = S_IDLE;
            end else begin
               next_done = extract_mask;
            end
         end
         S_FUSE: begin
            timer_enable = 1'b1;
            if (fuse_done) begin
               next_state = S_OUTPUT;
            end else if (timer_hit) begin
               next_err[ERR_TIMEOUT] = 1'b1;
               next_state            = S_IDLE;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               next_count = frame_count + 16'd1;
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      timer_clear = (next_state != state);
   end

   // State register. Every output is registered from the decided next state,
   // so a start pulse appears exactly in the first cycle of its stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         seen_mask   <= 4'h0;
         done_mask   <= 3'b000;
         error_flags <= 8'h00;
         frame_count <= 16'h0000;
         align_start <= 1'b0;
         feat_start  <= 1'b0;
         fuse_start  <= 1'b0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= next_state;
         seen_mask   <= next_seen;
         done_mask   <= next_done;
         error_flags <= next_err;
         frame_count <= next_count;
         align_start <= (next_state == S_ALIGN)   && (state != S_ALIGN);
         feat_start  <= (next_state == S_EXTRACT) && (state != S_EXTRACT);
         fuse_start  <= (next_state == S_FUSE)    && (state != S_FUSE);
         frame_valid <= (next_state == S_OUTPUT);
         busy        <= (next_state != S_IDLE);
      end
   end

endmodule

// File: tb/tb_fusion_pipeline_sequencer.sv
// Self-checking bench for fusion_pipeline_sequencer. A frame-level model
// tracks which pipeline phase the frame is in and how long it has waited
// there; every cycle the DUT outputs are compared against it, and a set of
// literal cycle-exact expectations pins the model to the required timing.
module tb_fusion_pipeline_sequencer;

   localparam int WIN = 16;
   localparam int STO = 32;

   localparam int P_IDLE    = 0;
   localparam int P_COLLECT = 1;
   localparam int P_ALIGN   = 2;
   localparam int P_EXTRACT = 3;
   localparam int P_FUSE    = 4;
   localparam int P_OUTPUT  = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  sensor_valid = 4'h0;
   logic        align_done = 1'b0;
   logic [2:0]  feat_done = 3'b000;
   logic        fuse_done = 1'b0;
   logic        out_ready = 1'b0;
   logic        err_clear = 1'b0;
   logic        align_start;
   logic        feat_start;
   logic        fuse_start;
   logic        frame_valid;
   logic        busy;
   logic [7:0]  error_flags;
   logic [15:0] frame_count;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   int          m_phase = P_IDLE;
   int          m_age = 0;
   logic [3:0]  m_seen = 4'h0;
   logic [2:0]  m_dmask = 3'b000;
   logic [7:0]  m_err = 8'h00;
   logic [15:0] m_count = 16'h0000;
   logic        e_as = 1'b0;
   logic        e_fs = 1'b0;
   logic        e_us = 1'b0;
   logic        e_fv = 1'b0;
   logic        e_busy = 1'b0;

   logic        saw_align_start = 1'b0;
   logic        saw_frame_valid = 1'b0;

   fusion_pipeline_sequencer #(
      .WINDOW_CYCLES (WIN),
      .STAGE_TIMEOUT (STO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sensor_valid (sensor_valid),
      .align_start  (align_start),
      .align_done   (align_done),
      .feat_start   (feat_start),
      .feat_done    (feat_done),
      .fuse_start   (fuse_start),
      .fuse_done    (fuse_done),
      .frame_valid  (frame_valid),
      .out_ready    (out_ready),
      .err_clear    (err_clear),
      .busy         (busy),
      .error_flags  (error_flags),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   // Frame-level model: advance one cycle given the inputs present before the edge.
   task automatic modelStep(input logic [3:0] sv, input logic ad, input logic [2:0] fd,
                            input logic fud, input logic ordy, input logic eclr, input logic rs);
      int         np;
      logic [3:0] seen_now;
      logic [2:0] done_now;
      logic [7:0] errs;
      if (rs) begin
         m_phase = P_IDLE; m_age = 0; m_seen = 4'h0; m_dmask = 3'b000;
         m_err = 8'h00; m_count = 16'h0000;
         e_as = 1'b0; e_fs = 1'b0; e_us = 1'b0; e_fv = 1'b0; e_busy = 1'b0;
      end else begin
         errs = eclr ? 8'h00 : m_err;
         if (ad && m_phase != P_ALIGN) errs[3] = 1'b1;
         if (fd != 3'b000 && m_phase != P_EXTRACT) errs[3] = 1'b1;
         if (fud && m_phase != P_FUSE) errs[3] = 1'b1;
         if (sv != 4'h0 && m_phase >= P_ALIGN) errs[1] = 1'b1;
         np = m_phase;
         case (m_phase)
            P_IDLE: if (sv != 4'h0) begin m_seen = sv; np = P_COLLECT; end
            P_COLLECT: begin
               seen_now = m_seen | sv;
               if (seen_now == 4'hF) begin np = P_ALIGN; m_seen = 4'h0; end
               else if (m_age == WIN - 1) begin
                  errs[0] = 1'b1; errs[7:4] = ~seen_now; m_seen = 4'h0; np = P_IDLE;
               end else m_seen = seen_now;
            end
            P_ALIGN: begin
               if (ad) np = P_EXTRACT;
               else if (m_age == STO - 1) begin errs[2] = 1'b1; np = P_IDLE; end
            end
            P_EXTRACT: begin
               done_now = m_dmask | fd;
               if (done_now == 3'b111) begin np = P_FUSE; m_dmask = 3'b000; end
               else if (m_age == STO - 1) begin errs[2] = 1'b1; np = P_IDLE; m_dmask = 3'b000; end
               else m_dmask = done_now;
            end
            P_FUSE: begin
               if (fud) np = P_OUTPUT;
               else if (m_age == STO - 1) begin errs[2] = 1'b1; np = P_IDLE; end
            end
            default: if (ordy) begin np = P_IDLE; m_count = m_count + 16'd1; end
         endcase
         m_age  = (np != m_phase) ? 0 : m_age + 1;
         e_as   = (np == P_ALIGN)   && (m_phase != P_ALIGN);
         e_fs   = (np == P_EXTRACT) && (m_phase != P_EXTRACT);
         e_us   = (np == P_FUSE)    && (m_phase != P_FUSE);
         e_fv   = (np == P_OUTPUT);
         e_busy = (np != P_IDLE);
         m_phase = np;
         m_err   = errs;
      end
   endtask

   task automatic compareField(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Compare every DUT output against the model after each edge.
   task automatic checkOutput();
      if (align_start === 1'b1) saw_align_start = 1'b1;
      if (frame_valid === 1'b1) saw_frame_valid = 1'b1;
      compareField("align_start", {15'd0, align_start}, {15'd0, e_as});
      compareField("feat_start",  {15'd0, feat_start},  {15'd0, e_fs});
      compareField("fuse_start",  {15'd0, fuse_start},  {15'd0, e_us});
      compareField("frame_valid", {15'd0, frame_valid}, {15'd0, e_fv});
      compareField("busy",        {15'd0, busy},        {15'd0, e_busy});
      compareField("error_flags", {8'd0, error_flags},  {8'd0, m_err});
      compareField("frame_count", frame_count,          m_count);
   endtask

   task automatic applyStimulus(input logic [3:0] sv, input logic ad, input logic [2:0] fd,
                                input logic fud, input logic ordy, input logic eclr, input logic rs);
      sensor_valid = sv; align_done = ad; feat_done = fd; fuse_done = fud;
      out_ready = ordy; err_clear = eclr; rst = rs;
      modelStep(sv, ad, fd, fud, ordy, eclr, rs);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Shortest legal frame: all sensors at once, each done one cycle after its start.
   task automatic quickFrame();
      applyStimulus(4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic checkLiteral(input string name, input logic [15:0] act, input logic [15:0] exp);
      compareField(name, act, exp);
   endtask

   initial begin
      logic [3:0] sv;
      logic [2:0] fd;

      // Reset state
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      checkLiteral("reset_busy", {15'd0, busy}, 16'd0);
      checkLiteral("reset_err", {8'd0, error_flags}, 16'h0000);
      checkLiteral("reset_count", frame_count, 16'h0000);
      idleCycles(1);

      // Reset during FUSE together with fuse_done and out_ready
      applyStimulus(4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
      checkLiteral("in_fuse_start", {15'd0, fuse_start}, 16'd1);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
      checkLiteral("rst_fuse_outs", {11'd0, align_start, feat_start, fuse_start, frame_valid, busy}, 16'd0);
      checkLiteral("rst_fuse_count", frame_count, 16'h0000);
      idleCycles(2);

      // Staggered sensors and stage handshakes with exact timing
      for (int t = 0; t <= 56; t++) begin
         sv = (t == 0) ? 4'h1 : (t == 3) ? 4'h2 : (t == 5) ? 4'h4 : (t == 9) ? 4'h8 : 4'h0;
         fd = (t == 30) ? 3'b101 : (t == 35) ? 3'b010 : 3'b000;
         applyStimulus(sv, t == 20, fd, t == 50, t == 55, 1'b0, 1'b0);
         if (t == 8)  checkLiteral("c9_align_start", {15'd0, align_start}, 16'd0);
         if (t == 9)  checkLiteral("c10_align_start", {15'd0, align_start}, 16'd1);
         if (t == 10) checkLiteral("c11_align_start", {15'd0, align_start}, 16'd0);
         if (t == 20) checkLiteral("c21_feat_start", {15'd0, feat_start}, 16'd1);
         if (t == 35) checkLiteral("c36_fuse_start", {15'd0, fuse_start}, 16'd1);
         if (t == 50) checkLiteral("c51_frame_valid", {15'd0, frame_valid}, 16'd1);
         if (t == 54) checkLiteral("c55_frame_valid", {15'd0, frame_valid}, 16'd1);
         if (t == 56) begin
            checkLiteral("c56_count", frame_count, 16'd1);
            checkLiteral("c56_busy", {15'd0, busy}, 16'd0);
         end
      end

      // Spurious done while idle, then clear
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      checkLiteral("spurious_err", {8'd0, error_flags}, 16'h0008);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      checkLiteral("spurious_clr", {8'd0, error_flags}, 16'h0000);

      // Window miss: imu never arrives
      saw_align_start = 1'b0;
      for (int t = 0; t <= 19; t++) begin
         sv = (t == 0) ? 4'h1 : (t == 1) ? 4'h2 : (t == 2) ? 4'h4 : 4'h0;
         applyStimulus(sv, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
         if (t == 15) checkLiteral("win_busy15", {15'd0, busy}, 16'd1);
         if (t == 16) begin
            checkLiteral("win_busy16", {15'd0, busy}, 16'd0);
            checkLiteral("win_err", {8'd0, error_flags}, 16'h0081);
         end
      end
      checkLiteral("win_no_align", {15'd0, saw_align_start}, 16'd0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

      // Alignment timeout, then a normal frame
      saw_frame_valid = 1'b0;
      applyStimulus(4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 35; t++) begin
         applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
         if (t == 32) checkLiteral("to_busy32", {15'd0, busy}, 16'd1);
         if (t == 33) begin
            checkLiteral("to_busy33", {15'd0, busy}, 16'd0);
            checkLiteral("to_err", {8'd0, error_flags}, 16'h0004);
         end
      end
      checkLiteral("to_no_frame", {15'd0, saw_frame_valid}, 16'd0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      quickFrame();
      checkLiteral("after_to_count", frame_count, 16'd2);

      // Overrun during EXTRACT, clear in the same frame
      applyStimulus(4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkLiteral("ovr_err", {8'd0, error_flags}, 16'h0002);
      applyStimulus(4'h0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
      checkLiteral("ovr_clr", {8'd0, error_flags}, 16'h0000);
      checkLiteral("ovr_fv", {15'd0, frame_valid}, 16'd1);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      checkLiteral("ovr_count", frame_count, 16'd3);

      // Wrap of frame_count from 16'hFFFF
      idleCycles(1);
      force dut.frame_count = 16'hFFFF;
      m_count = 16'hFFFF;
      idleCycles(1);
      release dut.frame_count;
      idleCycles(1);
      quickFrame();
      checkLiteral("wrap_count", frame_count, 16'h0000);
      idleCycles(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
